fp_div_arbiter: RTL and testbench

- Shares one multi-cycle bfloat16 divider (start/busy/valid interface, 16-bit operands, underflow/overflow/inexact flags) among NREQ requesters.
- Round-robin arbitration with per-requester valid/ready request and response channels.
- Sequences one division at a time: issues the start pulse, waits for completion, returns the result to the owning requester.
- Includes a watchdog timeout so a hung divider cannot deadlock the FPU.

---
 rtl/fp_div_arbiter.sv | 164 ++++++++++++++++
 tb/tb_fp_div_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_arbiter.sv
// Round-robin arbiter sharing one multi-cycle bfloat16 divider among NREQ requesters.
// One division in flight at a time; a watchdog forces a qNaN result if the divider hangs.
module fp_div_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_opA,
  input  logic [16*NREQ-1:0]   req_opB,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [15:0]          resp_quotient,
  output logic [2:0]           resp_flags,
  output logic                 resp_timeout,
  output logic                 div_start,
  output logic [15:0]          div_opA,
  output logic [15:0]          div_opB,
  input  logic [15:0]          div_quotient,
  input  logic                 div_underflow,
  input  logic                 div_overflow,
  input  logic                 div_inexact,
  input  logic                 div_valid,
  input  logic                 div_busy,
  output logic                 busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [15:0] QNAN = 16'h7FC0;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [15:0]   opa_q, opa_d;
  logic [15:0]   opb_q, opb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   quot_q, quot_d;
  logic [2:0]    flags_q, flags_d;
  logic          to_q, to_d;

  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] cand;

  // First asserted request at or after the pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % NREQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    flags_d = flags_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d = win_idx;
          opa_d   = req_opA[16*int'(win_idx) +: 16];
          opb_d   = req_opB[16*int'(win_idx) +: 16];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!div_busy) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A real result beats the watchdog when both land together.
        if (div_valid) begin
          quot_d  = div_quotient;
          flags_d = {div_underflow, div_overflow, div_inexact};
          to_d    = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          quot_d  = QNAN;
          flags_d = 3'b000;
          to_d    = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        if (resp_ready[grant_q]) begin
          ptr_d   = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + IW'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      flags_q <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      flags_q <= flags_d;
      to_q    <= to_d;
    end
  end

  // Ready is masked while reset is held so every output reads zero.
  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && win_found && !reset)
      req_ready[win_idx] = 1'b1;
  end

  always_comb begin
    resp_valid = '0;
    if (state_q == S_RESP)
      resp_valid[grant_q] = 1'b1;
  end

  assign div_start     = (state_q == S_ISSUE) && !div_busy;
  assign div_opA       = opa_q;
  assign div_opB       = opb_q;
  assign resp_quotient = quot_q;
  assign resp_flags    = flags_q;
  assign resp_timeout  = to_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Directed bench for fp_div_arbiter: arbitration order, back-pressure,
// watchdog, divider busy stall, spurious div_valid and async reset.
module tb_fp_div_arbiter;

  localparam int NREQ = 4;
  localparam int TMO  = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [16*NREQ-1:0] req_opA;
  logic [16*NREQ-1:0] req_opB;
  logic [NREQ-1:0] resp_valid;
  logic [NREQ-1:0] resp_ready;
  logic [15:0]     resp_quotient;
  logic [2:0]      resp_flags;
  logic            resp_timeout;
  logic            div_start;
  logic [15:0]     div_opA;
  logic [15:0]     div_opB;
  logic [15:0]     div_quotient;
  logic            div_underflow;
  logic            div_overflow;
  logic            div_inexact;
  logic            div_valid;
  logic            div_busy;
  logic            busy;

  int n_chk = 0;
  int n_fail = 0;

  fp_div_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opA(req_opA), .req_opB(req_opB),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_quotient(resp_quotient), .resp_flags(resp_flags),
    .resp_timeout(resp_timeout),
    .div_start(div_start), .div_opA(div_opA), .div_opB(div_opB),
    .div_quotient(div_quotient),
    .div_underflow(div_underflow), .div_overflow(div_overflow),
    .div_inexact(div_inexact),
    .div_valid(div_valid), .div_busy(div_busy),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req_valid = '0; resp_ready = '0; div_valid = 1'b0; div_busy = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  // One transaction with a lat-cycle divider; reports grant and response.
  task automatic run_txn(input logic [15:0] q, input int lat,
                         output int gnt, output logic [15:0] qo,
                         output logic to, output logic ok);
    logic [NREQ-1:0] rr;
    int n;
    ok = 1'b1; gnt = -1; qo = '0; to = 1'b0;
    #1;
    rr = req_ready;
    for (int i = 0; i < NREQ; i++) if (rr[i]) gnt = i;
    step();
    if (gnt >= 0) req_valid[gnt] = 1'b0;
    #1;
    n = 0;
    while (!div_start && n < 100) begin step(); #1; n++; end
    if (n == 100) begin ok = 1'b0; return; end
    for (int i = 1; i < lat; i++) step();
    step();
    div_valid = 1'b1; div_quotient = q;
    div_underflow = 1'b0; div_overflow = 1'b0; div_inexact = 1'b0;
    step();
    div_valid = 1'b0;
    #1;
    n = 0;
    while (resp_valid == '0 && n < 100) begin step(); #1; n++; end
    if (n == 100) begin ok = 1'b0; return; end
    qo = resp_quotient; to = resp_timeout;
    resp_ready = resp_valid;
    step();
    resp_ready = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req_valid = '0; req_opA = '0; req_opB = '0; resp_ready = '0;
    div_quotient = '0; div_underflow = 1'b0; div_overflow = 1'b0;
    div_inexact = 1'b0; div_valid = 1'b0; div_busy = 1'b0;
    step(); step();
    req_valid = 4'b1111;
    #1;
    n_chk++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_req_ready got %b exp 0000", req_ready); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_chk++; if (resp_valid !== 4'b0000) begin n_fail++; $display("FAIL rst_resp_valid got %b exp 0000", resp_valid); end
    n_chk++; if (div_start !== 1'b0) begin n_fail++; $display("FAIL rst_div_start got %b exp 0", div_start); end
    n_chk++; if ({div_opA, div_opB} !== 32'h0) begin n_fail++; $display("FAIL rst_div_ops got %h exp 0", {div_opA, div_opB}); end
    n_chk++; if ({resp_quotient, resp_flags, resp_timeout} !== 20'h0) begin n_fail++; $display("FAIL rst_resp_data got %h exp 0", {resp_quotient, resp_flags, resp_timeout}); end
    req_valid = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_single;
    req_opA[15:0] = 16'h4000; req_opB[15:0] = 16'h3F80;
    req_valid = 4'b0001;
    #1;
    n_chk++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready got %b exp 0001", req_ready); end
    n_chk++; if (div_start !== 1'b0) begin n_fail++; $display("FAIL single_start_c0 got %b exp 0", div_start); end
    step();
    req_valid = '0;
    #1;
    n_chk++; if (div_start !== 1'b1) begin n_fail++; $display("FAIL single_start_c1 got %b exp 1", div_start); end
    n_chk++; if (div_opA !== 16'h4000 || div_opB !== 16'h3F80) begin n_fail++; $display("FAIL single_ops got %h/%h exp 4000/3f80", div_opA, div_opB); end
    for (int i = 2; i <= 9; i++) step();
    #1;
    n_chk++; if (resp_valid !== 4'b0000 || div_start !== 1'b0) begin n_fail++; $display("FAIL single_wait got rv=%b st=%b exp 0000/0", resp_valid, div_start); end
    step();
    div_valid = 1'b1; div_quotient = 16'h4000;
    step();
    div_valid = 1'b0;
    #1;
    n_chk++; if (resp_valid !== 4'b0001) begin n_fail++; $display("FAIL single_resp_valid got %b exp 0001", resp_valid); end
    n_chk++; if (resp_quotient !== 16'h4000) begin n_fail++; $display("FAIL single_quot got %h exp 4000", resp_quotient); end
    n_chk++; if (resp_flags !== 3'b000 || resp_timeout !== 1'b0) begin n_fail++; $display("FAIL single_flags got %b/%b exp 000/0", resp_flags, resp_timeout); end
    resp_ready = 4'b0001;
    step();
    resp_ready = '0;
    #1;
    n_chk++; if (busy !== 1'b0 || resp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_done got busy=%b rv=%b exp 0/0000", busy, resp_valid); end
  endtask

  task automatic test_round_robin;
    int g; logic [15:0] qo; logic to, ok;
    int exp2 [2] = '{1, 3};
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_opA[16*i +: 16] = 16'h4000 + 16'(i);
      req_opB[16*i +: 16] = 16'h3F80;
    end
    req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      run_txn(16'h3F00 + 16'(i), 1, g, qo, to, ok);
      n_chk++; if (!ok || g != i) begin n_fail++; $display("FAIL rr_all_grant%0d got %0d ok=%b exp %0d", i, g, ok, i); end
      n_chk++; if (qo !== 16'h3F00 + 16'(i)) begin n_fail++; $display("FAIL rr_all_quot%0d got %h exp %h", i, qo, 16'h3F00 + 16'(i)); end
    end
    req_valid = 4'b1010;
    for (int i = 0; i < 2; i++) begin
      run_txn(16'h4100, 1, g, qo, to, ok);
      n_chk++; if (!ok || g != exp2[i]) begin n_fail++; $display("FAIL rr_sub_grant%0d got %0d ok=%b exp %0d", i, g, ok, exp2[i]); end
    end
  endtask

  task automatic test_back_pressure;
    req_opA[32 +: 16] = 16'h4040; req_opB[32 +: 16] = 16'h3F80;
    req_valid = 4'b0100;
    #1;
    n_chk++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_ready got %b exp 0100", req_ready); end
    step();
    req_valid = '0;
    #1;
    n_chk++; if (div_start !== 1'b1 || div_opA !== 16'h4040) begin n_fail++; $display("FAIL bp_issue got st=%b a=%h exp 1/4040", div_start, div_opA); end
    step();
    div_valid = 1'b1; div_quotient = 16'h4040; div_inexact = 1'b1;
    step();
    div_valid = 1'b0; div_inexact = 1'b0; div_quotient = 16'h0000;
    #1;
    n_chk++; if (resp_valid !== 4'b0100) begin n_fail++; $display("FAIL bp_resp_valid got %b exp 0100", resp_valid); end
    resp_ready = 4'b1011;
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      n_chk++; if (resp_valid !== 4'b0100 || resp_quotient !== 16'h4040 || resp_flags !== 3'b001) begin n_fail++; $display("FAIL bp_hold%0d got rv=%b q=%h f=%b exp 0100/4040/001", i, resp_valid, resp_quotient, resp_flags); end
      n_chk++; if (req_ready !== 4'b0000 || div_start !== 1'b0) begin n_fail++; $display("FAIL bp_quiet%0d got rdy=%b st=%b exp 0000/0", i, req_ready, div_start); end
      step(); #1;
    end
    resp_ready = 4'b0100;
    req_valid = '0;
    step();
    resp_ready = '0;
    #1;
    n_chk++; if (busy !== 1'b0 || resp_valid !== 4'b0000) begin n_fail++; $display("FAIL bp_release got busy=%b rv=%b exp 0/0000", busy, resp_valid); end
  endtask

  task automatic test_timeout;
    int g; logic [15:0] qo; logic to, ok;
    req_opA[15:0] = 16'h4200; req_opB[15:0] = 16'h4000;
    req_valid = 4'b0001;
    #1;
    n_chk++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL to_ready got %b exp 0001", req_ready); end
    step();
    req_valid = '0;
    #1;
    n_chk++; if (div_start !== 1'b1) begin n_fail++; $display("FAIL to_start got %b exp 1", div_start); end
    step();
    for (int i = 0; i < TMO - 1; i++) step();
    #1;
    n_chk++; if (resp_valid !== 4'b0000 || busy !== 1'b1) begin n_fail++; $display("FAIL to_early got rv=%b busy=%b exp 0000/1", resp_valid, busy); end
    step();
    #1;
    n_chk++; if (resp_valid !== 4'b0001) begin n_fail++; $display("FAIL to_resp_valid got %b exp 0001", resp_valid); end
    n_chk++; if (resp_quotient !== 16'h7FC0 || resp_flags !== 3'b000 || resp_timeout !== 1'b1) begin n_fail++; $display("FAIL to_data got q=%h f=%b t=%b exp 7fc0/000/1", resp_quotient, resp_flags, resp_timeout); end
    resp_ready = 4'b0001;
    step();
    resp_ready = '0;
    req_valid = 4'b0010;
    run_txn(16'h3F80, 3, g, qo, to, ok);
    n_chk++; if (!ok || g != 1 || qo !== 16'h3F80 || to !== 1'b0) begin n_fail++; $display("FAIL to_next got g=%0d q=%h t=%b ok=%b exp 1/3f80/0/1", g, qo, to, ok); end
  endtask

  task automatic test_div_busy;
    req_opA[32 +: 16] = 16'h4080; req_opB[32 +: 16] = 16'h4000;
    req_valid = 4'b0100;
    div_busy = 1'b1;
    #1;
    n_chk++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL busy_ready got %b exp 0100", req_ready); end
    step();
    req_valid = '0;
    for (int i = 1; i <= 3; i++) begin
      #1;
      n_chk++; if (div_start !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL busy_stall%0d got st=%b busy=%b exp 0/1", i, div_start, busy); end
      step();
    end
    div_busy = 1'b0;
    #1;
    n_chk++; if (div_start !== 1'b1) begin n_fail++; $display("FAIL busy_start got %b exp 1", div_start); end
    step();
    #1;
    n_chk++; if (div_start !== 1'b0) begin n_fail++; $display("FAIL busy_pulse got %b exp 0", div_start); end
    div_valid = 1'b1; div_quotient = 16'h4000;
    step();
    div_valid = 1'b0;
    #1;
    n_chk++; if (resp_valid !== 4'b0100 || resp_quotient !== 16'h4000) begin n_fail++; $display("FAIL busy_resp got rv=%b q=%h exp 0100/4000", resp_valid, resp_quotient); end
    resp_ready = 4'b0100;
    step();
    resp_ready = '0;
    div_valid = 1'b1; div_quotient = 16'h1234;
    step();
    div_valid = 1'b0;
    step(); step();
    #1;
    n_chk++; if (resp_valid !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_div_valid got rv=%b busy=%b exp 0000/0", resp_valid, busy); end
  endtask

  task automatic test_async_reset;
    int g; logic [15:0] qo; logic to, ok;
    req_opA[16 +: 16] = 16'h4400; req_opB[16 +: 16] = 16'h4000;
    req_valid = 4'b0010;
    #1;
    n_chk++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL ar_ready got %b exp 0010", req_ready); end
    step();
    req_valid = '0;
    step(); step();
    #3;
    reset = 1'b1;
    #1;
    n_chk++; if (busy !== 1'b0 || div_opA !== 16'h0 || div_opB !== 16'h0) begin n_fail++; $display("FAIL ar_clear got busy=%b a=%h b=%h exp 0/0/0", busy, div_opA, div_opB); end
    n_chk++; if (resp_quotient !== 16'h0 || resp_valid !== 4'b0000 || div_start !== 1'b0) begin n_fail++; $display("FAIL ar_outs got q=%h rv=%b st=%b exp 0/0000/0", resp_quotient, resp_valid, div_start); end
    step();
    reset = 1'b0;
    step();
    div_valid = 1'b1; div_quotient = 16'h5555;
    step();
    div_valid = 1'b0;
    step();
    #1;
    n_chk++; if (resp_valid !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL ar_late_valid got rv=%b busy=%b exp 0000/0", resp_valid, busy); end
    req_valid = 4'b1111;
    #1;
    n_chk++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL ar_ptr got %b exp 0001", req_ready); end
    req_valid = 4'b0001;
    run_txn(16'h3C00, 2, g, qo, to, ok);
    n_chk++; if (!ok || g != 0 || qo !== 16'h3C00) begin n_fail++; $display("FAIL ar_serve got g=%0d q=%h ok=%b exp 0/3c00/1", g, qo, ok); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_timeout();
    test_div_busy();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
